// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB types: default geometry and the Rid (index plus wrap bit) pointer type.
// Consumers: rob_alloc_ctrl, rob_range_mask and the bench.
package rob_alloc_ctrl_pkg;

   localparam int RENTRIES_DEF = 16;
   localparam int RSLOTS_DEF   = 2;
   localparam int CSLOTS_DEF   = 2;
   localparam int RID_W        = $clog2(RENTRIES_DEF) + 1;

   typedef logic [RID_W-1:0] rid_t;

endpackage

// File: rtl/rob_alloc_ctrl_range_mask.sv
// Wrap-around range mask: bit i is set when index i lies in [start_ptr, end_ptr)
// taken modulo 2*RENTRIES, so an empty range gives zero and a full range gives all ones.
module rob_range_mask
   import rob_alloc_ctrl_pkg::*;
#(
   parameter  int RENTRIES = RENTRIES_DEF,
   localparam int IW       = $clog2(RENTRIES),
   localparam int RW       = IW + 1
) (
   input  logic [RW-1:0]       start_ptr,
   input  logic [RW-1:0]       end_ptr,
   output logic [RENTRIES-1:0] mask
);

   logic [RW-1:0] span;

   assign span = end_ptr - start_ptr;

   genvar gi;
   generate
      for (gi = 0; gi < RENTRIES; gi++) begin : g_bit
         logic [IW-1:0] offset;
         // distance of this index from the start, measured forward around the ring
         assign offset   = IW'(gi) - start_ptr[IW-1:0];
         assign mask[gi] = RW'(offset) < span;
      end
   endgenerate

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation / retirement controller: head/tail pointers, entry-valid vector,
// per-cycle grants, head commits and branch-miss tail rollback. Optional ROB_STATS_EN.
module rob_alloc_ctrl
   import rob_alloc_ctrl_pkg::*;
#(
   parameter  int RENTRIES = RENTRIES_DEF,
   parameter  int RSLOTS   = RSLOTS_DEF,
   parameter  int CSLOTS   = CSLOTS_DEF,
   localparam int RW       = $clog2(RENTRIES) + 1,
   localparam int GW       = $clog2(RSLOTS + 1),
   localparam int CW       = $clog2(CSLOTS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [GW-1:0]       req_cnt,
   output logic [GW-1:0]       grant_cnt,
   output logic [RW-1:0]       grant_base,
   input  logic [CW-1:0]       commit_cnt,
   input  logic                flush,
   input  logic [RW-1:0]       flush_rid,
   output logic [RENTRIES-1:0] rob_v,
   output logic [RW-1:0]       rob_head,
   output logic [RW-1:0]       occ,
`ifdef ROB_STATS_EN
   output logic [31:0]         stall_cycles,
   output logic [31:0]         flush_count,
`endif
   output logic                full,
   output logic                empty
);

   typedef enum logic {RUN, RECOVER} state_t;

   state_t              state_reg, state_next;
   logic [RW-1:0]       head_reg, head_next;
   logic [RW-1:0]       tail_reg, tail_next;
   logic [RW-1:0]       occ_reg;
   logic [RENTRIES-1:0] rob_v_reg, rob_v_next;
   logic [RENTRIES-1:0] alloc_mask, commit_mask, flush_mask;
   logic [GW-1:0]       req_clamped;
   logic [RW-1:0]       free_slots;
   logic [RW-1:0]       flush_start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= RUN;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = RUN;
      if (flush) state_next = RECOVER;
   end

   // Free space comes from registered occupancy, so commit_cnt never reaches the grant.
   always_comb begin
      req_clamped = (req_cnt > GW'(RSLOTS)) ? GW'(RSLOTS) : req_cnt;
      free_slots  = RW'(RENTRIES) - occ_reg;
      grant_cnt   = '0;
      if (rst_n && state_reg == RUN && !flush)
         grant_cnt = (RW'(req_clamped) > free_slots) ? GW'(free_slots) : req_clamped;
   end

   assign flush_start = flush_rid + RW'(1);
   assign head_next   = head_reg + RW'(commit_cnt);
   assign tail_next   = flush ? flush_start : tail_reg + RW'(grant_cnt);

   rob_range_mask #(.RENTRIES(RENTRIES)) u_alloc_mask (
      .start_ptr (tail_reg),
      .end_ptr   (tail_reg + RW'(grant_cnt)),
      .mask      (alloc_mask)
   );

   rob_range_mask #(.RENTRIES(RENTRIES)) u_commit_mask (
      .start_ptr (head_reg),
      .end_ptr   (head_next),
      .mask      (commit_mask)
   );

   // A zero-length range when no flush keeps the flush mask empty.
   rob_range_mask #(.RENTRIES(RENTRIES)) u_flush_mask (
      .start_ptr (flush_start),
      .end_ptr   (flush ? tail_reg : flush_start),
      .mask      (flush_mask)
   );

   assign rob_v_next = (rob_v_reg | alloc_mask) & ~(commit_mask | flush_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         occ_reg   <= '0;
         rob_v_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         occ_reg   <= tail_next - head_next;
         rob_v_reg <= rob_v_next;
      end
   end

`ifdef ROB_STATS_EN
   logic [31:0] stall_cycles_reg, flush_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (req_cnt != '0 && grant_cnt < req_clamped) stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (flush) flush_count_reg <= flush_count_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`endif

   assign grant_base = tail_reg;
   assign rob_v      = rob_v_reg;
   assign rob_head   = head_reg;
   assign occ        = occ_reg;
   assign full       = (occ_reg == RW'(RENTRIES));
   assign empty      = (occ_reg == '0);

endmodule
